// File: rtl/sum_stationary_pkg.sv
// Shared types for the sum-stationary processing element: default element types,
// the ACCUM/DRAIN state encoding and a row-counter width helper.
package sum_stationary_pkg;

  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_ACCUM_WIDTH = 32;

  typedef logic signed [DEF_DATA_WIDTH-1:0]  data_t;
  typedef logic signed [DEF_ACCUM_WIDTH-1:0] accum_t;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_DRAIN = 1'b1
  } pe_state_e;

  // A single-row array still needs a 1-bit counter to keep port widths legal.
  function automatic int row_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pe_operand_slot.sv
// One-entry operand holding slot: captures a broadcast vector addressed to this
// element and holds it (with its last flag) until the pair is consumed.
module pe_operand_slot
  import sum_stationary_pkg::*;
#(
  parameter int N            = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int ID_BITS      = 4,
  parameter int PROCESSOR_ID = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_valid,
  input  logic [ID_BITS-1:0]        i_id,
  input  logic [N*DATA_WIDTH-1:0]   i_data,
  input  logic                      i_last,
  input  pe_state_e                 i_state,
  input  logic                      i_fire,
  input  logic                      i_pair_last,
  output logic                      o_ready,
  output logic                      o_full,
  output logic                      o_last,
  output logic [N*DATA_WIDTH-1:0]   o_data
);

  logic                    r_full;
  logic                    r_last;
  logic [N*DATA_WIDTH-1:0] r_data;
  logic                    w_accept;

  // A slot being consumed this cycle can be refilled, unless the pair ends the operation.
  assign o_ready  = (i_state == ST_ACCUM) && (!r_full || (i_fire && !i_pair_last));
  assign w_accept = i_valid && o_ready && (i_id == ID_BITS'(PROCESSOR_ID));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_full <= 1'b0;
      r_last <= 1'b0;
      r_data <= '0;
    end else if (w_accept) begin
      r_full <= 1'b1;
      r_last <= i_last;
      r_data <= i_data;
    end else if (i_fire) begin
      r_full <= 1'b0;
      r_last <= 1'b0;
    end
  end

  assign o_full = r_full;
  assign o_last = r_last;
  assign o_data = r_data;

endmodule

// File: rtl/sum_stationary_pe.sv
// Output-stationary PE: accumulates outer products of A rows and B columns into an
// N x N array, then drains it one row per handshake before accepting new work.
module sum_stationary_pe
  import sum_stationary_pkg::*;
#(
  parameter int DATA_WIDTH                 = $bits(data_t),
  parameter int N                          = 4,
  parameter int ACCUM_WIDTH                = $bits(accum_t),
  parameter int PROCESSORS_ID_COUNTER_BITS = 4,
  parameter int PROCESSOR_ID               = 0,
  localparam int ROW_W                     = row_bits(N)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  a_input_valid,
  output logic                                  a_input_ready,
  input  logic [PROCESSORS_ID_COUNTER_BITS-1:0] a_input_id,
  input  logic [N*DATA_WIDTH-1:0]               a_input_data,
  input  logic                                  a_last,
  input  logic                                  b_input_valid,
  output logic                                  b_input_ready,
  input  logic [PROCESSORS_ID_COUNTER_BITS-1:0] b_input_id,
  input  logic [N*DATA_WIDTH-1:0]               b_input_data,
  input  logic                                  b_last,
  output logic                                  result_valid,
  input  logic                                  result_ready,
  output logic [N*ACCUM_WIDTH-1:0]              result_data,
  output logic [ROW_W-1:0]                      result_row_index,
  output logic                                  result_last,
  output logic                                  protocol_error
);

  localparam int PW = 2 * DATA_WIDTH;

  pe_state_e                      r_state;
  logic [ROW_W-1:0]               r_row;
  logic                           r_protocol_error;
  logic signed [ACCUM_WIDTH-1:0]  r_acc  [N][N];
  logic signed [ACCUM_WIDTH-1:0]  w_prod [N][N];

  logic                    w_a_full, w_a_last, w_b_full, w_b_last;
  logic [N*DATA_WIDTH-1:0] w_a_data, w_b_data;
  logic                    w_fire, w_pair_last, w_row_last;
  logic [N*ACCUM_WIDTH-1:0] w_result_data;

  assign w_fire      = (r_state == ST_ACCUM) && w_a_full && w_b_full;
  assign w_pair_last = w_a_last || w_b_last;
  assign w_row_last  = (r_row == ROW_W'(N - 1));

  pe_operand_slot #(
    .N(N), .DATA_WIDTH(DATA_WIDTH), .ID_BITS(PROCESSORS_ID_COUNTER_BITS), .PROCESSOR_ID(PROCESSOR_ID)
  ) u_slot_a (
    .clk(clk), .reset(reset),
    .i_valid(a_input_valid), .i_id(a_input_id), .i_data(a_input_data), .i_last(a_last),
    .i_state(r_state), .i_fire(w_fire), .i_pair_last(w_pair_last),
    .o_ready(a_input_ready), .o_full(w_a_full), .o_last(w_a_last), .o_data(w_a_data)
  );

  pe_operand_slot #(
    .N(N), .DATA_WIDTH(DATA_WIDTH), .ID_BITS(PROCESSORS_ID_COUNTER_BITS), .PROCESSOR_ID(PROCESSOR_ID)
  ) u_slot_b (
    .clk(clk), .reset(reset),
    .i_valid(b_input_valid), .i_id(b_input_id), .i_data(b_input_data), .i_last(b_last),
    .i_state(r_state), .i_fire(w_fire), .i_pair_last(w_pair_last),
    .o_ready(b_input_ready), .o_full(w_b_full), .o_last(w_b_last), .o_data(w_b_data)
  );

  // Full-precision signed product, then sign-extended (or wrapped) to accumulator width.
  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      logic signed [PW-1:0] w_mul;
      assign w_mul = $signed(w_a_data[gi*DATA_WIDTH +: DATA_WIDTH]) *
                     $signed(w_b_data[gj*DATA_WIDTH +: DATA_WIDTH]);
      if (PW >= ACCUM_WIDTH) begin : g_trunc
        assign w_prod[gi][gj] = w_mul[ACCUM_WIDTH-1:0];
      end else begin : g_sext
        assign w_prod[gi][gj] = {{(ACCUM_WIDTH-PW){w_mul[PW-1]}}, w_mul};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state          <= ST_ACCUM;
      r_row            <= '0;
      r_protocol_error <= 1'b0;
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          r_acc[i][j] <= '0;
    end else begin
      case (r_state)
        ST_ACCUM: begin
          if (w_fire) begin
            for (int i = 0; i < N; i++)
              for (int j = 0; j < N; j++)
                r_acc[i][j] <= r_acc[i][j] + w_prod[i][j];
            if (w_a_last != w_b_last)
              r_protocol_error <= 1'b1;
            if (w_pair_last) begin
              r_state <= ST_DRAIN;
              r_row   <= '0;
            end
          end
        end
        ST_DRAIN: begin
          if (result_ready) begin
            if (w_row_last) begin
              r_state <= ST_ACCUM;
              r_row   <= '0;
              for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                  r_acc[i][j] <= '0;
            end else begin
              r_row <= r_row + 1'b1;
            end
          end
        end
        default: r_state <= ST_ACCUM;
      endcase
    end
  end

  always_comb begin
    w_result_data = '0;
    if (r_state == ST_DRAIN)
      for (int j = 0; j < N; j++)
        w_result_data[j*ACCUM_WIDTH +: ACCUM_WIDTH] = r_acc[r_row][j];
  end

  assign result_valid     = (r_state == ST_DRAIN);
  assign result_last      = (r_state == ST_DRAIN) && w_row_last;
  assign result_row_index = r_row;
  assign result_data      = w_result_data;
  assign protocol_error   = r_protocol_error;

endmodule
